// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with NREGS 8-bit registers behind an auto-incrementing pointer.
// Latency: each bus event acts 3 CLK after its pin edge (2-flop sync + edge flop); wr_strobe is a 1-CLK pulse.
// Backpressure: none; the master paces everything through SCL and the block never stretches the clock.
// Ports: CLK, Reset (synchronous, active-high); SCL, iSDA raw bus pins; oSDA_en open-drain pull-down;
//        wr_strobe/wr_index/wr_data report each committed byte; regs_flat exposes all registers;
//        busy is high while a transaction addressed to this device is in progress.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREGS    = 4,
  parameter int         PW       = $clog2(NREGS)
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 SCL,
  input  logic                 iSDA,
  output logic                 oSDA_en,
  output logic                 wr_strobe,
  output logic [PW-1:0]        wr_index,
  output logic [7:0]           wr_data,
  output logic [8*NREGS-1:0]   regs_flat,
  output logic                 busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // Synchronizers and edge-detect flops; idle bus level is high.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      scl_s1 <= SCL;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= iSDA;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  // SCL must be high on both sides of the SDA edge, so an SDA change that
  // coincides with an SCL edge is never taken for a bus condition.
  assign start_det = ~sda_s2 & sda_d & scl_s2 & scl_d;
  assign stop_det  = sda_s2 & ~sda_d & scl_s2 & scl_d;

  state_t          state;
  logic [2:0]      bitcnt;
  logic [6:0]      shreg;
  logic [6:0]      txbyte;   // remaining read bits; bit 7 is on the wire already
  logic            rw;
  logic            ackph;    // 0: waiting to drive/release first half, 1: second half of ACK bit
  logic [PW-1:0]   ptr;
  logic [7:0]      regs [NREGS];

  logic [7:0] rx_byte;
  assign rx_byte = {shreg, sda_s2};

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      txbyte    <= '0;
      rw        <= 1'b0;
      ackph     <= 1'b0;
      ptr       <= '0;
      oSDA_en   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bitcnt  <= '0;
        ackph   <= 1'b0;
        oSDA_en <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        oSDA_en <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg  <= rx_byte[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              rw    <= sda_s2;
              ackph <= 1'b0;
              state <= (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
            end
          end

          // Falling edge after the 8th bit pulls SDA, falling edge after the 9th releases it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ackph) begin
              oSDA_en <= 1'b1;
              ackph   <= 1'b1;
            end else begin
              ackph  <= 1'b0;
              bitcnt <= '0;
              if (state == ADDR_ACK && rw) begin
                // Read starts on this same edge: latch the byte and drive its MSB.
                state   <= RDATA;
                txbyte  <= regs[ptr][6:0];
                oSDA_en <= ~regs[ptr][7];
              end else begin
                oSDA_en <= 1'b0;
                state   <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end

          PTR: if (scl_rise) begin
            shreg  <= rx_byte[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              ptr   <= rx_byte[PW-1:0];
              ackph <= 1'b0;
              state <= PTR_ACK;
            end
          end

          // Commit happens only on the 8th bit, so an aborted byte never writes.
          WDATA: if (scl_rise) begin
            shreg  <= rx_byte[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              regs[ptr] <= rx_byte;
              wr_strobe <= 1'b1;
              wr_index  <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr + PW'(1);
              ackph     <= 1'b0;
              state     <= WDATA_ACK;
            end
          end

          RDATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                ackph <= 1'b0;
                state <= RDATA_ACK;
              end
            end else if (scl_fall) begin
              oSDA_en <= ~txbyte[6];
              txbyte  <= {txbyte[5:0], 1'b0};
            end
          end

          RDATA_ACK: begin
            if (scl_fall) begin
              if (ackph) begin
                state   <= RDATA;
                bitcnt  <= '0;
                txbyte  <= regs[ptr][6:0];
                oSDA_en <= ~regs[ptr][7];
                ackph   <= 1'b0;
              end else begin
                oSDA_en <= 1'b0;
              end
            end else if (scl_rise) begin
              ptr <= ptr + PW'(1);
              if (sda_s2) state <= IGNORE;
              else        ackph <= 1'b1;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE) && (state != IGNORE);

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
  localparam int NREGS = 4;
  localparam int PW    = 2;
  localparam int Q     = 40;   // quarter SCL period; SCL period = 16 CLK

  logic CLK = 1'b0;
  logic Reset, SCL, sda_m, iSDA;
  logic oSDA_en, wr_strobe, busy;
  logic [PW-1:0] wr_index;
  logic [7:0] wr_data;
  logic [8*NREGS-1:0] regs_flat;

  always #5 CLK = ~CLK;

  // Wired-AND bus: master's drive combined with the slave's open-drain pull-down.
  assign iSDA = sda_m & ~oSDA_en;

  i2c_slave_regfile #(.DEV_ADDR(7'h50), .NREGS(NREGS)) dut (
    .CLK(CLK), .Reset(Reset), .SCL(SCL), .iSDA(iSDA), .oSDA_en(oSDA_en),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .wr_data(wr_data),
    .regs_flat(regs_flat), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: log every strobe and count cycles the slave pulls SDA.
  logic [9:0] stb_log [256];
  int nstb = 0;
  int osda_cnt = 0;
  always @(negedge CLK) begin
    if (wr_strobe === 1'b1) begin
      if (nstb < 256) stb_log[nstb] <= {wr_index, wr_data};
      nstb <= nstb + 1;
    end
    if (oSDA_en === 1'b1) osda_cnt <= osda_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; #Q; SCL = 1'b1; #Q; s = iSDA; #Q; SCL = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q; SCL = 1'b1; #Q; sda_m = 1'b0; #Q; SCL = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q; SCL = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(mack, s);
  endtask

  task automatic pulse_reset;
    @(negedge CLK) Reset = 1'b1;
    @(negedge CLK) Reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]    addr;
    logic [7:0]    pbyte;
    logic [7:0]    dbyte;
    logic          acked;
    logic [PW-1:0] idx;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         base;
    int         oc;
    int         nacks;

    vecs[0] = '{8'hA0, 8'h00, 8'h5A, 1'b1, 2'd0};
    vecs[1] = '{8'hA0, 8'h07, 8'hC3, 1'b1, 2'd3};  // upper pointer bits ignored
    vecs[2] = '{8'hA0, 8'hFE, 8'h81, 1'b1, 2'd2};
    vecs[3] = '{8'hA2, 8'h01, 8'hFF, 1'b0, 2'd0};  // address 0x51
    vecs[4] = '{8'h20, 8'h02, 8'hEE, 1'b0, 2'd0};  // address 0x10
    vecs[5] = '{8'hA0, 8'h01, 8'h96, 1'b1, 2'd1};

    Reset = 1'b1; SCL = 1'b1; sda_m = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) Reset = 1'b0;
    #1;
    chk("rst oSDA_en", oSDA_en, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_strobe", wr_strobe, 0);
    chk("rst wr_index", wr_index, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst regs", regs_flat, 0);

    // Table-driven single-byte writes
    for (int i = 0; i < 6; i++) begin
      base = nstb;
      i2c_start();
      wbyte(vecs[i].addr, ack);  chk("vec addr ack", ack, vecs[i].acked);
      wbyte(vecs[i].pbyte, ack); chk("vec ptr ack", ack, vecs[i].acked);
      wbyte(vecs[i].dbyte, ack); chk("vec data ack", ack, vecs[i].acked);
      i2c_stop();
      chk("vec strobes", nstb - base, vecs[i].acked ? 1 : 0);
      if (vecs[i].acked && nstb > base)
        chk("vec strobe idx/data", stb_log[base], {vecs[i].idx, vecs[i].dbyte});
      chk("vec busy after stop", busy, 0);
    end
    chk("vec regs", regs_flat, 32'hC3_81_96_5A);
    pulse_reset();
    #1 chk("reset clears regs", regs_flat, 0);

    // Bad address: no ACK ever, IGNORE until STOP
    base = nstb; oc = osda_cnt;
    i2c_start();
    wbyte(8'hAA, ack); chk("badaddr ack", ack, 0);
    chk("badaddr busy", busy, 0);
    wbyte(8'h3C, ack); chk("badaddr 2nd byte ack", ack, 0);
    chk("badaddr osda cycles", osda_cnt - oc, 0);
    chk("badaddr strobes", nstb - base, 0);
    i2c_stop();

    // Write burst
    base = nstb; nacks = 0;
    i2c_start();
    chk("burst busy after start", busy, 1);
    wbyte(8'hA0, ack); nacks += ack;
    wbyte(8'h01, ack); nacks += ack;
    wbyte(8'h3C, ack); nacks += ack;
    wbyte(8'h7E, ack); nacks += ack;
    i2c_stop();
    chk("burst acks", nacks, 4);
    chk("burst strobes", nstb - base, 2);
    chk("burst strobe0", stb_log[base], {2'd1, 8'h3C});
    chk("burst strobe1", stb_log[base+1], {2'd2, 8'h7E});
    chk("burst regs", regs_flat, 32'h00_7E_3C_00);

    // Pointer wrap
    base = nstb;
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h03, ack); wbyte(8'h11, ack); wbyte(8'h22, ack);
    i2c_stop();
    chk("wrap strobe0", stb_log[base], {2'd3, 8'h11});
    chk("wrap strobe1", stb_log[base+1], {2'd0, 8'h22});
    chk("wrap regs", regs_flat, 32'h11_7E_3C_22);
    i2c_start();
    wbyte(8'hA1, ack); chk("wrap read addr ack", ack, 1);
    rbyte(1'b1, d);    chk("wrap ptr is 1", d, 8'h3C);
    i2c_stop();

    // Pointer write, repeated START, two-byte read
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h01, ack);
    i2c_start();
    wbyte(8'hA1, ack); chk("read addr ack", ack, 1);
    rbyte(1'b0, d);    chk("read byte1", d, 8'h3C);
    rbyte(1'b1, d);    chk("read byte2", d, 8'h7E);
    chk("read sda released", oSDA_en, 0);
    chk("read busy after nack", busy, 0);
    i2c_stop();
    i2c_start();
    wbyte(8'hA1, ack);
    rbyte(1'b1, d);    chk("read ptr now 3", d, 8'h11);
    i2c_stop();

    // STOP after 4 data bits: no write
    base = nstb;
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h02, ack);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    i2c_stop();
    chk("stop abort strobes", nstb - base, 0);
    chk("stop abort busy", busy, 0);
    chk("stop abort regs", regs_flat, 32'h11_7E_3C_22);

    // Repeated START after 4 data bits: no write, pointer not advanced
    base = nstb;
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h00, ack);
    clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    i2c_start();
    wbyte(8'hA1, ack);
    rbyte(1'b1, d);    chk("start abort readback", d, 8'h22);
    i2c_stop();
    chk("start abort strobes", nstb - base, 0);

    // Reset during RDATA (regs[1]=3C: leading zeros make the slave pull SDA)
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h01, ack);
    i2c_start();
    wbyte(8'hA1, ack);
    clk_bit(1'b1, s);
    chk("rdata driving", oSDA_en, 1);
    @(negedge CLK) Reset = 1'b1;
    @(posedge CLK); #1;
    chk("midreset osda", oSDA_en, 0);
    chk("midreset regs", regs_flat, 0);
    chk("midreset busy", busy, 0);
    @(negedge CLK) Reset = 1'b0;
    wbyte(8'hA0, ack); chk("no resume without start", ack, 0);
    i2c_stop();
    base = nstb;
    i2c_start();
    wbyte(8'hA0, ack); wbyte(8'h00, ack); wbyte(8'h55, ack);
    i2c_stop();
    chk("post reset write ack", ack, 1);
    chk("post reset strobe", stb_log[base], {2'd0, 8'h55});
    chk("post reset regs", regs_flat, 32'h00_00_00_55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
